// File: rtl/register_transfer_arbiter.sv
// rtl/register_transfer_arbiter.sv - two-port round-robin move sequencer for the A/B/C/P/S/ST register file
//
// Purpose: grants one register move at a time to either the instruction decoder
// (port 0) or the debug/IO unit (port 1), then drives Register_Control_Bus
// through SETUP (source output enable) and XFER (enable plus destination load).
//
// Ports:
//   clock_in, reset_n         clock, asynchronous active-low reset
//   req_valid[1:0]            move request per requester
//   req_src/req_dst[5:0]      {port1, port0} 3-bit codes: 0 EXT, 1-6 A,B,C,P,S,ST, 7 illegal
//   req_ready[1:0]            one-cycle acceptance pulse
//   done[1:0]                 one-cycle completion pulse, three cycles after ready
//   err[1:0]                  illegal-code pulse, coincident with ready
//   Register_Control_Bus[11:0] [5:0] one-hot loads, [11:6] one-hot output enables
//   ext_drive, ext_capture    external unit drives / samples the bus
//   busy                      FSM not idle
module register_transfer_arbiter #(
    parameter int NREQ   = 2,
    parameter int CODE_W = 3
) (
    input  logic                   clock_in,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CODE_W-1:0] req_src,
    input  logic [NREQ*CODE_W-1:0] req_dst,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        err,
    output logic [11:0]            Register_Control_Bus,
    output logic                   ext_drive,
    output logic                   ext_capture,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CODE_W-1:0] C_EXT = '0;
    localparam logic [CODE_W-1:0] C_ILL = '1;

    logic [1:0]        r_state;
    logic              r_ptr;      // requester favoured on a tie
    logic              r_gnt;      // requester owning the current move
    logic [CODE_W-1:0] r_dst;
    logic [NREQ-1:0]   r_ready;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   r_err;
    logic [11:0]       r_rcb;
    logic              r_ext_drive;
    logic              r_ext_capture;

    logic [NREQ-1:0]   w_req;
    logic              w_gnt;
    logic [NREQ-1:0]   w_gnt_vec;
    logic [CODE_W-1:0] w_src;
    logic [CODE_W-1:0] w_dst;
    logic              w_illegal;

    function automatic logic [5:0] f_onehot(input logic [CODE_W-1:0] code);
        logic [5:0] v;
        v = 6'b0;
        for (int i = 0; i < 6; i++) begin
            if (code == CODE_W'(i + 1)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // A requester still sees its ready pulse while its valid is high; masking it
    // keeps an illegal request (which leaves us in IDLE) from being taken twice.
    assign w_req     = req_valid & ~r_ready;
    assign w_gnt     = (w_req[0] && w_req[1]) ? r_ptr : w_req[1];
    assign w_gnt_vec = w_gnt ? 2'b10 : 2'b01;
    assign w_src     = w_gnt ? req_src[2*CODE_W-1:CODE_W] : req_src[CODE_W-1:0];
    assign w_dst     = w_gnt ? req_dst[2*CODE_W-1:CODE_W] : req_dst[CODE_W-1:0];
    assign w_illegal = (w_src == C_ILL) || (w_dst == C_ILL) ||
                       ((w_src == C_EXT) && (w_dst == C_EXT));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= 1'b0;
            r_gnt         <= 1'b0;
            r_dst         <= '0;
            r_ready       <= '0;
            r_done        <= '0;
            r_err         <= '0;
            r_rcb         <= 12'h000;
            r_ext_drive   <= 1'b0;
            r_ext_capture <= 1'b0;
        end else begin
            r_ready <= '0;
            r_done  <= '0;
            r_err   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_ready <= w_gnt_vec;
                        r_gnt   <= w_gnt;
                        r_dst   <= w_dst;
                        if (w_illegal) begin
                            r_err <= w_gnt_vec;
                            r_ptr <= ~w_gnt;
                        end else begin
                            // Outputs are loaded one state early so they are pure flops.
                            r_state     <= S_SETUP;
                            r_rcb       <= {f_onehot(w_src), 6'b0};
                            r_ext_drive <= (w_src == C_EXT);
                        end
                    end
                end
                S_SETUP: begin
                    r_state       <= S_XFER;
                    r_rcb[5:0]    <= f_onehot(r_dst);
                    r_ext_capture <= (r_dst == C_EXT);
                end
                S_XFER: begin
                    r_state       <= S_DONE;
                    r_rcb         <= 12'h000;
                    r_ext_drive   <= 1'b0;
                    r_ext_capture <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= r_gnt ? 2'b10 : 2'b01;
                    r_ptr   <= ~r_gnt;
                end
            endcase
        end
    end

    assign req_ready            = r_ready;
    assign done                 = r_done;
    assign err                  = r_err;
    assign Register_Control_Bus = r_rcb;
    assign ext_drive            = r_ext_drive;
    assign ext_capture          = r_ext_capture;
    assign busy                 = (r_state != S_IDLE);

endmodule

// File: tb/tb_register_transfer_arbiter.sv
// tb/tb_register_transfer_arbiter.sv - scoreboard bench for register_transfer_arbiter
module tb_register_transfer_arbiter;

    logic        clock_in;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [5:0]  req_src;
    logic [5:0]  req_dst;
    logic [1:0]  req_ready;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [11:0] Register_Control_Bus;
    logic        ext_drive;
    logic        ext_capture;
    logic        busy;

    register_transfer_arbiter dut (
        .clock_in             (clock_in),
        .reset_n              (reset_n),
        .req_valid            (req_valid),
        .req_src              (req_src),
        .req_dst              (req_dst),
        .req_ready            (req_ready),
        .done                 (done),
        .err                  (err),
        .Register_Control_Bus (Register_Control_Bus),
        .ext_drive            (ext_drive),
        .ext_capture          (ext_capture),
        .busy                 (busy)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Register file model: A,B,C,P,S,ST at indices 0..5
    logic [15:0] rf [6];
    logic [15:0] data_bus;
    logic [15:0] ext_data;
    logic        preload_en;

    always_comb begin
        data_bus = 16'h0000;
        if (ext_drive) data_bus = ext_data;
        for (int i = 0; i < 6; i++) begin
            if (Register_Control_Bus[6+i]) data_bus = rf[i];
        end
    end

    always @(negedge clock_in) begin
        if (preload_en) begin
            rf[0] <= 16'h1234;
            rf[1] <= 16'h0000;
            rf[2] <= 16'hC0DE;
            rf[3] <= 16'h5A5A;
            rf[4] <= 16'h0000;
            rf[5] <= 16'h0000;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (Register_Control_Bus[i]) rf[i] <= data_bus;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        bit          is_err;
        bit          abort;
        logic [11:0] rcb_s;
        logic [11:0] rcb_x;
        bit          ed;
        bit          ec;
        logic [15:0] cap;
    } exp_t;

    exp_t exp_q[$];

    task automatic push(input int port, input bit is_err, input bit abort,
                        input logic [11:0] rcb_s, input logic [11:0] rcb_x,
                        input bit ed, input bit ec, input logic [15:0] cap);
        exp_t e;
        e.port = port; e.is_err = is_err; e.abort = abort;
        e.rcb_s = rcb_s; e.rcb_x = rcb_x; e.ed = ed; e.ec = ec; e.cap = cap;
        exp_q.push_back(e);
    endtask

    // Monitor: every ready pulse pops one expected move and follows it to done
    exp_t       m_e;
    logic [1:0] m_pv;
    initial begin
        forever begin
            @(negedge clock_in);
            if (reset_n && req_ready != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {30'b0, req_ready}, 32'h0);
                end else begin
                    m_e  = exp_q.pop_front();
                    m_pv = (m_e.port == 1) ? 2'b10 : 2'b01;
                    check("grant", {30'b0, req_ready}, {30'b0, m_pv});
                    check("err", {30'b0, err}, m_e.is_err ? {30'b0, m_pv} : 32'h0);
                    if (m_e.is_err) begin
                        check("err_rcb", {20'b0, Register_Control_Bus}, 32'h0);
                        check("err_busy", {31'b0, busy}, 32'h0);
                        check("err_ext", {30'b0, ext_drive, ext_capture}, 32'h0);
                    end else begin
                        check("setup_rcb", {20'b0, Register_Control_Bus}, {20'b0, m_e.rcb_s});
                        check("setup_ext", {30'b0, ext_drive, ext_capture}, {30'b0, m_e.ed, 1'b0});
                        check("setup_busy", {31'b0, busy}, 32'h1);
                        if (!m_e.abort) begin
                            @(negedge clock_in);
                            check("xfer_rcb", {20'b0, Register_Control_Bus}, {20'b0, m_e.rcb_x});
                            check("xfer_ext", {30'b0, ext_drive, ext_capture}, {30'b0, m_e.ed, m_e.ec});
                            check("xfer_done", {30'b0, done}, 32'h0);
                            if (m_e.ec) check("ext_capture_data", {16'b0, data_bus}, {16'b0, m_e.cap});
                            @(negedge clock_in);
                            check("done_state_rcb", {20'b0, Register_Control_Bus}, 32'h0);
                            check("done_state_busy", {31'b0, busy}, 32'h1);
                            check("done_early", {30'b0, done}, 32'h0);
                            @(negedge clock_in);
                            check("done_pulse", {30'b0, done}, {30'b0, m_pv});
                            check("idle_busy", {31'b0, busy}, 32'h0);
                        end
                    end
                end
            end
        end
    end

    task automatic move(input int port, input logic [2:0] src, input logic [2:0] dst);
        int cyc;
        @(negedge clock_in);
        req_valid[port] = 1'b1;
        if (port == 0) begin req_src[2:0] = src; req_dst[2:0] = dst; end
        else           begin req_src[5:3] = src; req_dst[5:3] = dst; end
        cyc = 0;
        do begin
            @(negedge clock_in);
            cyc++;
        end while (!req_ready[port] && cyc < 20);
        req_valid[port] = 1'b0;
        check("ready_latency", cyc, 1);
    endtask

    initial begin
        int cnt;
        int cyc;
        reset_n    = 1'b0;
        preload_en = 1'b1;
        req_valid  = 2'b00;
        req_src    = 6'o00;
        req_dst    = 6'o00;
        ext_data   = 16'hBEEF;
        repeat (3) @(negedge clock_in);
        check("reset_outputs", {req_ready, done, err, Register_Control_Bus, ext_drive, ext_capture, busy}, 32'h0);
        reset_n    = 1'b1;
        preload_en = 1'b0;
        @(negedge clock_in);
        check("post_reset_outputs", {req_ready, done, err, Register_Control_Bus, ext_drive, ext_capture, busy}, 32'h0);

        // A -> B
        push(0, 0, 0, 12'h040, 12'h042, 0, 0, 16'h0);
        move(0, 3'd1, 3'd2);
        repeat (4) @(negedge clock_in);
        check("B_value", {16'b0, rf[1]}, 32'h1234);

        // EXT -> ST on port 1
        push(1, 0, 0, 12'h000, 12'h020, 1, 0, 16'h0);
        move(1, 3'd0, 3'd6);
        repeat (4) @(negedge clock_in);
        check("ST_value", {16'b0, rf[5]}, 32'hBEEF);

        // Both held, C -> S: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) push(i % 2, 0, 0, 12'h100, 12'h110, 0, 0, 16'h0);
        @(negedge clock_in);
        req_src = {3'd3, 3'd3};
        req_dst = {3'd5, 3'd5};
        req_valid = 2'b11;
        cnt = 0;
        cyc = 0;
        while (cnt < 4 && cyc < 60) begin
            @(negedge clock_in);
            cyc++;
            if (req_ready != 2'b00) cnt++;
        end
        req_valid = 2'b00;
        check("held_grant_count", cnt, 4);
        repeat (4) @(negedge clock_in);
        check("S_value", {16'b0, rf[4]}, 32'hC0DE);

        // P -> EXT
        push(0, 0, 0, 12'h200, 12'h200, 0, 1, 16'h5A5A);
        move(0, 3'd4, 3'd0);
        repeat (4) @(negedge clock_in);

        // Illegal: EXT -> EXT, then code 7
        push(0, 1, 0, 12'h0, 12'h0, 0, 0, 16'h0);
        move(0, 3'd0, 3'd0);
        repeat (3) @(negedge clock_in);
        check("err1_no_done", {30'b0, done}, 32'h0);
        push(0, 1, 0, 12'h0, 12'h0, 0, 0, 16'h0);
        move(0, 3'd7, 3'd1);
        repeat (3) @(negedge clock_in);
        check("err2_no_done", {30'b0, done}, 32'h0);

        // Reset during XFER of A -> B
        push(0, 0, 1, 12'h040, 12'h042, 0, 0, 16'h0);
        move(0, 3'd1, 3'd2);
        @(negedge clock_in);
        check("abort_xfer_rcb", {20'b0, Register_Control_Bus}, 32'h042);
        reset_n = 1'b0;
        #1;
        check("abort_rcb", {20'b0, Register_Control_Bus}, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_flags", {req_ready, done, err, ext_drive, ext_capture}, 32'h0);
        @(negedge clock_in);
        reset_n = 1'b1;
        repeat (3) @(negedge clock_in);
        check("abort_no_done", {30'b0, done}, 32'h0);

        // Tie after reset: requester 0 must win
        push(0, 0, 0, 12'h040, 12'h044, 0, 0, 16'h0);
        req_src = {3'd2, 3'd1};
        req_dst = {3'd4, 3'd3};
        req_valid = 2'b11;
        @(negedge clock_in);
        req_valid = 2'b00;
        check("tie_after_reset", {30'b0, req_ready}, 32'h1);
        repeat (4) @(negedge clock_in);
        check("C_value", {16'b0, rf[2]}, 32'h1234);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
